// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the nv_ram family: init FSM state encoding and an
// even-parity helper used when NV_RAM_PARITY_EN is defined.
package nv_ram_pkg;

  typedef enum logic [0:0] {
    StInit  = 1'b0,
    StReady = 1'b1
  } init_state_e;

  localparam int unsigned MaxWidth = 256;

  // Even parity bit: set when the word has an odd number of ones.
  function automatic logic parity(input logic [MaxWidth-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nv_ram_init_ctl.sv
// Post-reset clear sweep: writes zero to every word, one per cycle, then reports ready.
module nv_ram_init_ctl
  import nv_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 80,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          init_done_o
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  init_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_we_o   = 1'b0;
    clr_addr_o = cnt_q;
    unique case (state_q)
      StInit: begin
        clr_we_o = 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      StReady: begin
        state_d = StReady;
      end
    endcase
  end

  assign init_done_o = (state_q == StReady);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/nv_ram_rwsthp_param.sv
// Two-stage registered-read RAM with write-first forwarding, output bypass and a
// post-reset clear sweep. Optional stored parity under macro NV_RAM_PARITY_EN.
module nv_ram_rwsthp_param
  import nv_ram_pkg::*;
#(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 80,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             rd_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic             byp_sel,
  input  logic [WIDTH-1:0] dbyp,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic             init_done,
  output logic             par_err
);

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  nv_ram_init_ctl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_ctl (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr),
    .init_done_o (init_done)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wa_ok, ra_ok, user_we, fwd, mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata, rd_word;

  logic             s1_vld_q, s1_vld_d;
  logic [AW-1:0]    s1_addr_q, s1_addr_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_vld_q, rd_vld_d;

  // Write and read ports; the clear sweep owns the write port while not ready.
  always_comb begin
    wa_ok     = 32'(wa) < DEPTH;
    ra_ok     = 32'(ra) < DEPTH;
    user_we   = init_done & we & wa_ok;
    fwd       = user_we & re & (wa == ra);
    mem_we    = clr_we | user_we;
    mem_waddr = clr_we ? clr_addr : wa;
    mem_wdata = clr_we ? '0 : di;
    rd_word   = '0;
    if (ra_ok) begin
      rd_word = fwd ? di : mem_q[ra];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Stage 1 holds captured data, so later writes to the same address cannot disturb it.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_addr_d = s1_addr_q;
    s1_data_d = s1_data_q;
    if (init_done && re) begin
      s1_vld_d  = 1'b1;
      s1_addr_d = ra;
      s1_data_d = rd_word;
    end else if (ore) begin
      s1_vld_d = 1'b0;
    end
    dout_d   = dout_q;
    rd_vld_d = rd_vld_q;
    if (ore) begin
      dout_d   = byp_sel ? dbyp : s1_data_q;
      rd_vld_d = s1_vld_q | byp_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      dout_q    <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      s1_data_q <= s1_data_d;
      dout_q    <= dout_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign dout   = dout_q;
  assign rd_vld = rd_vld_q;

`ifdef NV_RAM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic mem_wpar, rd_par;
  logic s1_par_q, s1_par_d;
  logic par_err_q, par_err_d;

  always_comb begin
    mem_wpar = clr_we ? 1'b0 : parity(MaxWidth'(di));
    rd_par   = 1'b0;
    if (ra_ok) begin
      rd_par = fwd ? parity(MaxWidth'(di)) : par_mem_q[ra];
    end
    s1_par_d = (init_done && re) ? rd_par : s1_par_q;
    par_err_d = par_err_q;
    if (ore) begin
      par_err_d = (!byp_sel && s1_vld_q) ? (parity(MaxWidth'(s1_data_q)) != s1_par_q) : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem_q[mem_waddr] <= mem_wpar;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_par_q  <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      s1_par_q  <= s1_par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  // Power-down bus and stage-1 address are retained for compatibility only.
  logic unused_sigs;
  assign unused_sigs = ^{pwrbus_ram_pd, s1_addr_q};

endmodule

// File: doc/nv_ram_rwsthp_param.md
NV_RAM_RWSTHP_PARAM -- requirements
Module: nv_ram_rwsthp_param

Interface
REQ-001 Parameter WIDTH, default 17: data word width in bits, range 1..256.
REQ-002 Parameter DEPTH, default 80: number of words, range 2..4096.
REQ-003 Parameter AW, default $clog2(DEPTH): address width; derived, never overridden.
REQ-004 Port clk, input, 1: the single clock; all state updates on posedge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port ra, input, AW: read address.
REQ-007 Port re, input, 1: read enable; captures ra into stage 1.
REQ-008 Port ore, input, 1: output register enable; advances stage 1 to dout.
REQ-009 Port dout, output, WIDTH: registered read data.
REQ-010 Port rd_vld, output, 1: dout holds data from a completed read or bypass.
REQ-011 Port wa, input, AW: write address.
REQ-012 Port we, input, 1: write enable.
REQ-013 Port di, input, WIDTH: write data.
REQ-014 Port byp_sel, input, 1: select dbyp instead of RAM data at the output register.
REQ-015 Port dbyp, input, WIDTH: bypass data.
REQ-016 Port pwrbus_ram_pd, input, 32: power-down bus; functionally ignored, kept for drop-in compatibility.
REQ-017 Port init_done, output, 1: high once the post-reset clear sweep has finished.
REQ-018 Port par_err, output, 1: parity error on the current dout (see Configuration).

Function
REQ-019 Init FSM states INIT and READY shall exist; reset enters INIT with clear counter 0.
REQ-020 In INIT, each cycle: write all-zero word to M[cnt], cnt+1; after cnt==DEPTH-1 is written, go to READY; sweep takes exactly DEPTH cycles.
REQ-021 In INIT, we and re are ignored; init_done is 0; in READY init_done is 1.
REQ-022 In READY, we with wa<DEPTH writes di to M[wa] at posedge; wa>=DEPTH is a dropped write.
REQ-023 re in READY: stage-1 address register <= ra, s1_vld <= 1; else if ore: s1_vld <= 0; otherwise hold.
REQ-024 Same-cycle we && re && wa==ra: stage 1 captures di (write-first forwarding), not the old word.
REQ-025 Stage-1 read of ra>=DEPTH yields all-zero data.
REQ-026 ore: dout <= byp_sel ? dbyp : stage-1 data; rd_vld <= s1_vld | byp_sel; no ore: dout and rd_vld hold.
REQ-027 Latency: re in cycle N and ore in cycle N+1 give data on dout in cycle N+2.
REQ-028 A write to the stage-1 address after capture does not alter the captured data.

Reset
REQ-029 rst sets dout=0, rd_vld=0, par_err=0, s1_vld=0, stage-1 address=0, state=INIT, cnt=0.
REQ-030 rst asserted mid-sweep restarts the sweep at address 0; memory contents are not otherwise reset.

Configuration
REQ-031 Macro NV_RAM_PARITY_EN defined: each word stores an extra even-parity bit of di, written on every write and cleared to 0 by the init sweep.
REQ-032 With NV_RAM_PARITY_EN: on ore with byp_sel=0 and s1_vld=1, par_err <= recomputed parity != stored parity; otherwise on ore par_err <= 0.
REQ-033 Without NV_RAM_PARITY_EN: no parity storage; par_err is constant 0.

Structure
REQ-034 Shared package nv_ram_pkg holds the INIT/READY state enum and a parity function.
REQ-035 One sub-module nv_ram_init_ctl implements the init FSM and clear counter, driving the clear write port and init_done.

Verification
REQ-036 Reset with DEPTH=80 -> init_done rises exactly 80 cycles after rst drops; all reads then return 0.
REQ-037 Write 0x1ABCD to wa=5, then re with ra=5, then ore -> dout=0x1ABCD, rd_vld=1 two cycles after re.
REQ-038 we wa=9 di=0x00F0F with re ra=9 in the same cycle (old word 0) -> dout=0x00F0F after ore.
REQ-039 byp_sel=1, dbyp=0x15555, ore with s1_vld=0 -> dout=0x15555, rd_vld=1, par_err=0.
REQ-040 rst at sweep cycle 40 -> init_done stays 0 for a further 80 cycles; we during INIT leaves memory unchanged.
REQ-041 NV_RAM_PARITY_EN: force-flip one stored bit at address 3, read it -> par_err=1 with rd_vld=1; next clean read -> par_err=0.
